wb_mailbox_slave: RTL and testbench

- Wishbone classic slave (responder) on the wrapper's wbs_* port, answering accesses initiated by the management core.
- Provides two word FIFOs as a mailbox between the management core and soc_core:
  - M2U: management to user.
  - U2M: user to management.
- Also provides a status/control register and a scratch register.
- User side is exposed as valid/ready streams plus a level interrupt.

---
 rtl/wb_mailbox_pkg.sv | 23 ++
 rtl/mbox_fifo.sv | 79 +++++++
 rtl/wb_mailbox_slave.sv | 186 ++++++++++++++++++
 tb/tb_wb_mailbox_slave.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_mailbox_pkg.sv
// Purpose: shared constants for the Wishbone mailbox (register offsets, STATUS bit positions, default depth).
// Latency: n/a (constants only).
// Backpressure: n/a.
package wb_mailbox_pkg;

    localparam int DEFAULT_DEPTH = 8;

    // Register select, decoded from adr[3:2]
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_SCRATCH = 2'd2;

    // STATUS bit positions
    localparam int ST_M2U_EMPTY = 0;
    localparam int ST_M2U_FULL  = 1;
    localparam int ST_U2M_EMPTY = 2;
    localparam int ST_U2M_FULL  = 3;
    localparam int ST_OVF       = 8;
    localparam int ST_UDF       = 9;
    localparam int ST_CNT_LO    = 16;
    localparam int ST_IRQ_EN    = 31;

endpackage

// File: rtl/mbox_fifo.sv
// Purpose: synchronous word FIFO with occupancy count; head entry shown combinationally on rdata.
// Latency: a push is visible at the head one cycle later; a pop advances the head at the next edge.
// Backpressure: push while full is dropped unless a pop is accepted in the same cycle; pop while empty is ignored.
//
// Ports: clk, rst (sync, active-high); push/wdata write side; pop/rdata read side;
//        full, empty, count reflect registered occupancy.
module mbox_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CNT_MAX);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A pop on a full FIFO frees the slot that a same-cycle push then fills.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observable while count says so.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/wb_mailbox_slave.sv
// Purpose: Wishbone classic slave exposing an M2U/U2M word mailbox, STATUS/control and SCRATCH registers.
// Latency: one access sampled per ack; ack and read data registered one cycle after the strobe is sampled.
// Backpressure: bus never stalls (full/empty set sticky ovf/udf); user side uses valid/ready.
//
// Ports: wb_clk_i/wb_rst_i (sync, active-high); wbs_* Wishbone slave; m2u_* stream to the user;
//        u2m_* stream from the user; irq_o registered level interrupt.
module wb_mailbox_slave
    import wb_mailbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = DEFAULT_DEPTH,
    parameter int          CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] m2u_data_o,
    output logic        m2u_valid_o,
    input  logic        m2u_ready_i,
    input  logic [31:0] u2m_data_i,
    input  logic        u2m_valid_i,
    output logic        u2m_ready_o,
    output logic        irq_o
);

    logic             ack_q, ack_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             irq_en_q, irq_en_d;
    logic             irq_q, irq_d;
    logic [31:0]      scratch_q, scratch_d;

    logic             req, hit, bus_wr, bus_rd;
    logic [1:0]       reg_sel;
    logic             m2u_push, m2u_full, m2u_empty;
    logic             u2m_pop, u2m_full, u2m_empty;
    logic [31:0]      u2m_head;
    logic [CNT_W-1:0] m2u_count, u2m_count;
    logic [7:0]       u2m_cnt8;
    logic [31:0]      status_word, rd_mux;
    logic             unused_ok;

    // Gating on the pending ack stops a held strobe from being sampled twice.
    assign req     = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign hit     = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_sel = wbs_adr_i[3:2];
    assign bus_wr  = req & hit & wbs_we_i;
    assign bus_rd  = req & hit & ~wbs_we_i;

    assign m2u_push = bus_wr & (reg_sel == REG_DATA);
    assign u2m_pop  = bus_rd & (reg_sel == REG_DATA);

    mbox_fifo #(.WIDTH(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_m2u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (m2u_push),
        .pop   (m2u_ready_i),
        .wdata (wbs_dat_i),
        .rdata (m2u_data_o),
        .full  (m2u_full),
        .empty (m2u_empty),
        .count (m2u_count)
    );

    // The user push goes straight in: the FIFO accepts it while full only if the bus pops that cycle.
    mbox_fifo #(.WIDTH(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_u2m_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (u2m_valid_i),
        .pop   (u2m_pop),
        .wdata (u2m_data_i),
        .rdata (u2m_head),
        .full  (u2m_full),
        .empty (u2m_empty),
        .count (u2m_count)
    );

    assign m2u_valid_o = ~m2u_empty;
    assign u2m_ready_o = ~u2m_full;

    generate
        if (CNT_W >= 8) begin : g_cnt_trunc
            assign u2m_cnt8 = u2m_count[7:0];
        end else begin : g_cnt_ext
            assign u2m_cnt8 = {{(8 - CNT_W){1'b0}}, u2m_count};
        end
    endgenerate

    always_comb begin
        status_word                            = '0;
        status_word[ST_M2U_EMPTY]              = m2u_empty;
        status_word[ST_M2U_FULL]               = m2u_full;
        status_word[ST_U2M_EMPTY]              = u2m_empty;
        status_word[ST_U2M_FULL]               = u2m_full;
        status_word[ST_OVF]                    = ovf_q;
        status_word[ST_UDF]                    = udf_q;
        status_word[ST_CNT_LO +: 8]            = u2m_cnt8;
        status_word[ST_IRQ_EN]                 = irq_en_q;
    end

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_DATA:    rd_mux = u2m_empty ? 32'h0 : u2m_head;
            REG_STATUS:  rd_mux = status_word;
            REG_SCRATCH: rd_mux = scratch_q;
            default:     rd_mux = '0;
        endcase
    end

    always_comb begin
        ack_d     = req;
        rdata_d   = rdata_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        irq_en_d  = irq_en_q;
        scratch_d = scratch_q;
        irq_d     = irq_en_q & (~u2m_empty | ovf_q | udf_q);

        // A full M2U with a same-cycle user pop still accepts the push.
        if (m2u_push && m2u_full && !m2u_ready_i) begin
            ovf_d = 1'b1;
        end
        if (u2m_pop && u2m_empty) begin
            udf_d = 1'b1;
        end

        if (bus_wr && reg_sel == REG_STATUS) begin
            if (wbs_dat_i[ST_OVF]) begin
                ovf_d = 1'b0;
            end
            if (wbs_dat_i[ST_UDF]) begin
                udf_d = 1'b0;
            end
            irq_en_d = wbs_dat_i[ST_IRQ_EN];
        end

        if (bus_wr && reg_sel == REG_SCRATCH) begin
            for (int b = 0; b < 4; b++) begin
                if (wbs_sel_i[b]) begin
                    scratch_d[8*b +: 8] = wbs_dat_i[8*b +: 8];
                end
            end
        end

        // Any read (hit or miss) refreshes the data register; writes leave it untouched.
        if (req && !wbs_we_i) begin
            rdata_d = bus_rd ? rd_mux : 32'h0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
            scratch_q <= '0;
        end else begin
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
            scratch_q <= scratch_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdata_q;
    assign irq_o     = irq_q;

    assign unused_ok = ^{wbs_adr_i[1:0], m2u_count};

endmodule

// File: tb/tb_wb_mailbox_slave.sv
// Purpose: directed bench for wb_mailbox_slave with a queue-based reference model and per-cycle compare.
// Latency: model tracks ack/read data one cycle after each sampled strobe, irq one cycle after its cause.
// Backpressure: model applies full/empty drop rules and the same-cycle push/pop exception.
module tb_wb_mailbox_slave;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 8;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [31:0] m2u_data_o;
    logic        m2u_valid_o;
    logic        m2u_ready_i = 1'b0;
    logic [31:0] u2m_data_i = 32'h0;
    logic        u2m_valid_i = 1'b0;
    logic        u2m_ready_o;
    logic        irq_o;

    wb_mailbox_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .m2u_data_o  (m2u_data_o),
        .m2u_valid_o (m2u_valid_o),
        .m2u_ready_i (m2u_ready_i),
        .u2m_data_i  (u2m_data_i),
        .u2m_valid_i (u2m_valid_i),
        .u2m_ready_o (u2m_ready_o),
        .irq_o       (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int total = 0;
    int bad   = 0;
    bit armed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_m2u[$];
    logic [31:0] m_u2m[$];
    bit          m_ovf, m_udf, m_irq_en, m_ack, m_irq;
    logic [31:0] m_dat, m_scratch;

    always @(posedge wb_clk_i) begin
        bit          req, hit, m_pop, b_pop, next_irq;
        int          m2u_n, u2m_n;
        logic [1:0]  r;
        logic [31:0] rd;
        if (wb_rst_i) begin
            m_m2u.delete();
            m_u2m.delete();
            m_ovf = 0; m_udf = 0; m_irq_en = 0; m_ack = 0; m_irq = 0;
            m_dat = 32'h0; m_scratch = 32'h0;
        end else begin
            next_irq = m_irq_en && (m_u2m.size() != 0 || m_ovf || m_udf);
            req   = wbs_cyc_i && wbs_stb_i && !m_ack;
            hit   = (wbs_adr_i[31:4] == BASE[31:4]);
            r     = wbs_adr_i[3:2];
            m2u_n = m_m2u.size();
            u2m_n = m_u2m.size();
            m_pop = m2u_ready_i && (m2u_n > 0);
            b_pop = 0;
            rd    = 32'h0;
            if (m_pop) void'(m_m2u.pop_front());
            if (req && hit) begin
                if (!wbs_we_i) begin
                    case (r)
                        2'd0: if (u2m_n > 0) begin rd = m_u2m.pop_front(); b_pop = 1; end
                              else m_udf = 1;
                        2'd1: rd = {m_irq_en, 7'b0, 8'(u2m_n), 6'b0, m_udf, m_ovf, 4'b0,
                                    (u2m_n == DEPTH), (u2m_n == 0), (m2u_n == DEPTH), (m2u_n == 0)};
                        2'd2: rd = m_scratch;
                        default: rd = 32'h0;
                    endcase
                end else begin
                    case (r)
                        2'd0: if (m2u_n < DEPTH || m_pop) m_m2u.push_back(wbs_dat_i);
                              else m_ovf = 1;
                        2'd1: begin
                            if (wbs_dat_i[8]) m_ovf = 0;
                            if (wbs_dat_i[9]) m_udf = 0;
                            m_irq_en = wbs_dat_i[31];
                        end
                        2'd2: for (int b = 0; b < 4; b++)
                                  if (wbs_sel_i[b]) m_scratch[8*b +: 8] = wbs_dat_i[8*b +: 8];
                        default: ;
                    endcase
                end
            end
            if (u2m_valid_i && (u2m_n < DEPTH || b_pop)) m_u2m.push_back(u2m_data_i);
            if (req && !wbs_we_i) m_dat = rd;
            m_ack = req;
            m_irq = next_irq;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge wb_clk_i) begin
        if (armed) begin
            chk("cmp_ack", wbs_ack_o, m_ack);
            chk("cmp_dat", wbs_dat_o, m_dat);
            chk("cmp_m2u_valid", m2u_valid_o, (m_m2u.size() != 0));
            if (m_m2u.size() != 0) chk("cmp_m2u_data", m2u_data_o, m_m2u[0]);
            chk("cmp_u2m_ready", u2m_ready_o, (m_u2m.size() < DEPTH));
            chk("cmp_irq", irq_o, m_irq);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic upush, input logic [31:0] udat,
                       output logic [31:0] rdata);
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        u2m_valid_i = upush; u2m_data_i = udat;
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; u2m_valid_i = 0;
        chk("ack_next_cycle", wbs_ack_o, 1'b1);
        rdata = wbs_dat_o;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] d;
        bus(1'b1, adr, dat, 4'hF, 1'b0, 32'h0, d);
    endtask

    task automatic rd(input string nm, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        bus(1'b0, adr, 32'h0, 4'hF, 1'b0, 32'h0, d);
        chk(nm, d, exp);
    endtask

    task automatic upush(input logic [31:0] d);
        @(posedge wb_clk_i); #1;
        u2m_valid_i = 1; u2m_data_i = d;
        @(posedge wb_clk_i); #1;
        u2m_valid_i = 0;
    endtask

    initial begin
        logic [31:0] d;
        repeat (3) @(posedge wb_clk_i);
        #1; armed = 1;
        @(negedge wb_clk_i);
        chk("rst_ack", wbs_ack_o, 1'b0);
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk("rst_irq", irq_o, 1'b0);
        chk("rst_u2m_ready", u2m_ready_o, 1'b1);
        chk("rst_m2u_valid", m2u_valid_o, 1'b0);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 0;

        // Reset status
        rd("status_reset", BASE + 32'h4, 32'h0000_0005);

        // M2U fill plus overflow
        for (int k = 1; k <= 8; k++) wr(BASE, 32'hA5A5_0000 + 32'(k));
        wr(BASE, 32'hDEAD_BEEF);
        rd("status_m2u_full_ovf", BASE + 32'h4, 32'h0000_0106);
        @(posedge wb_clk_i); #1;
        m2u_ready_i = 1;
        for (int k = 1; k <= 8; k++) begin
            chk("m2u_pop_order", m2u_data_o, 32'hA5A5_0000 + 32'(k));
            @(posedge wb_clk_i); #1;
        end
        m2u_ready_i = 0;
        chk("m2u_drained", m2u_valid_o, 1'b0);
        rd("status_ovf_held", BASE + 32'h4, 32'h0000_0105);
        wr(BASE + 32'h4, 32'h0000_0100);
        rd("status_ovf_cleared", BASE + 32'h4, 32'h0000_0005);

        // U2M reads, interrupt, underflow
        upush(32'h11);
        upush(32'h22);
        wr(BASE + 32'h4, 32'h8000_0000);
        chk("irq_lag", irq_o, 1'b0);
        @(posedge wb_clk_i); #1;
        chk("irq_rise", irq_o, 1'b1);
        rd("status_cnt2", BASE + 32'h4, 32'h8002_0001);
        rd("u2m_read_0x11", BASE, 32'h11);
        rd("u2m_read_0x22", BASE, 32'h22);
        @(posedge wb_clk_i); #1;
        chk("irq_fall", irq_o, 1'b0);
        rd("u2m_read_empty", BASE, 32'h0);
        @(posedge wb_clk_i); #1;
        chk("irq_udf", irq_o, 1'b1);
        rd("status_udf", BASE + 32'h4, 32'h8000_0205);
        wr(BASE + 32'h4, 32'h0000_0200);

        // U2M full with simultaneous push and pop
        @(posedge wb_clk_i); #1;
        u2m_valid_i = 1;
        for (int i = 0; i < 8; i++) begin
            u2m_data_i = 32'h100 + 32'(i);
            @(posedge wb_clk_i); #1;
        end
        u2m_valid_i = 0;
        chk("u2m_full_ready", u2m_ready_o, 1'b0);
        bus(1'b0, BASE, 32'h0, 4'hF, 1'b1, 32'h1FF, d);
        chk("full_pushpop_data", d, 32'h100);
        chk("full_pushpop_ready", u2m_ready_o, 1'b0);
        rd("status_cnt8", BASE + 32'h4, 32'h0008_0009);
        for (int i = 1; i < 8; i++) rd("u2m_drain", BASE, 32'h100 + 32'(i));
        rd("u2m_drain_last", BASE, 32'h1FF);
        rd("status_after_drain", BASE + 32'h4, 32'h0000_0005);

        // SCRATCH byte enables
        wr(BASE + 32'h8, 32'hFFFF_FFFF);
        bus(1'b1, BASE + 32'h8, 32'h1234_5678, 4'b0101, 1'b0, 32'h0, d);
        rd("scratch_sel", BASE + 32'h8, 32'hFF34_FF78);

        // Window miss and unused offset
        rd("miss_read", BASE + 32'h10, 32'h0);
        wr(BASE + 32'h10, 32'h77);
        chk("miss_no_push", m2u_valid_o, 1'b0);
        wr(BASE + 32'hC, 32'h55);
        rd("reg_c_read", BASE + 32'hC, 32'h0);

        // Reset while a DATA write is pending
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1;
        wbs_adr_i = BASE; wbs_dat_i = 32'hCAFE_0001; wbs_sel_i = 4'hF;
        @(negedge wb_clk_i);
        wb_rst_i = 1;
        @(posedge wb_clk_i); #1;
        chk("rst_cancel_ack", wbs_ack_o, 1'b0);
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        wb_rst_i = 0;
        @(posedge wb_clk_i); #1;
        chk("rst_cancel_ack2", wbs_ack_o, 1'b0);
        chk("rst_cancel_m2u", m2u_valid_o, 1'b0);

        repeat (3) @(posedge wb_clk_i);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
